// File: rtl/riscv_pkg.sv
// Shared RV32I constants for the multicycle core: opcodes, PC source
// encodings and the reset instruction word. The control FSM uses the same
// package, so both sides agree on what each opcode and PCSource value means.
package riscv_pkg;

  // Base-ISA major opcodes (instruction bits [6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // PCSource strobe meaning: take the live ALU result or the latched ALUOut
  localparam logic PCSRC_ALU    = 1'b0;
  localparam logic PCSRC_ALUOUT = 1'b1;

  // addi x0,x0,0 -- what the IR holds after reset so decode sees a harmless op
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // A PC target is only legal when it sits on a 4-byte boundary
  function automatic logic isWordAligned(input logic [1:0] lowBits);
    return (lowBits == 2'b00);
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: turns the instruction register into the 32-bit
// sign-extended immediate for whichever RV32I format the opcode selects.
// R-type and unknown opcodes produce zero so the datapath never sees junk.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] ir,
  output logic [31:0] imm
);

  // Pick the immediate layout from the opcode field
  always_comb begin
    imm = '0;
    case (ir[6:0])
      OP_IMM, OP_LOAD, OP_JALR:
        imm = {{20{ir[31]}}, ir[31:20]};
      OP_STORE:
        imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH:
        imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {ir[31:12], 12'b0};
      OP_JAL:
        imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/pc_ir_unit.sv
// Front-end register stage of the multicycle RV32I core. Owns PC, IR, MDR
// and ALUOut, steers the unified-memory address, and presents the decoded
// instruction fields and immediate to the control FSM and datapath.
module pc_ir_unit #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCWrite,
  input  logic             PCWriteCond,
  input  logic             PCSource,
  input  logic             IorD,
  input  logic             IRWrite,
  input  logic             MemRead,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             alu_zero,
  input  logic [31:0]      mem_rdata,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  aluout,
  output logic [31:0]      mdr,
  output logic [6:0]       opcode,
  output logic [4:0]       rd,
  output logic [2:0]       funct3,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [6:0]       funct7,
  output logic [XLEN-1:0]  imm,
  output logic             misalign_err
);

  logic [31:0]     ir;
  logic [31:0]     imm32;
  logic [XLEN-1:0] pcNext;
  logic            pcEn;

  // Branches only redirect when the ALU comparison came out zero
  assign pcEn   = PCWrite | (PCWriteCond & alu_zero);
  assign pcNext = (PCSource == riscv_pkg::PCSRC_ALUOUT) ? aluout : alu_result;

  // Memory address is combinational so the fetch sees the pre-edge PC
  assign mem_addr = IorD ? aluout : pc;

  // PC update; low bits are forced to zero and a misaligned target is
  // remembered until the next reset so software can inspect it later
  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
    end else if (pcEn) begin
      pc <= {pcNext[XLEN-1:2], 2'b00};
      if (!riscv_pkg::isWordAligned(pcNext[1:0])) begin
        misalign_err <= 1'b1;
      end
    end
  end

  // Instruction register loads only on IRWrite; fetch captures the word at
  // the old PC because mem_addr was formed before this edge
  always_ff @(posedge clk) begin
    if (reset) begin
      ir <= NOP_INSTR;
    end else if (IRWrite) begin
      ir <= mem_rdata;
    end
  end

  // Memory data register only captures data-side reads, never fetches
  always_ff @(posedge clk) begin
    if (reset) begin
      mdr <= '0;
    end else if (MemRead && IorD) begin
      mdr <= mem_rdata;
    end
  end

  // ALUOut follows the ALU every cycle so the next state can reuse it
  always_ff @(posedge clk) begin
    if (reset) begin
      aluout <= '0;
    end else begin
      aluout <= alu_result;
    end
  end

  // Fixed-position instruction fields
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  imm_gen u_immGen (
    .ir  (ir),
    .imm (imm32)
  );

  // Widen the 32-bit immediate to the datapath width, keeping its sign
  assign imm = XLEN'(signed'(imm32));

endmodule

// File: tb/tb_pc_ir_unit.sv
// Bench for pc_ir_unit: directed scenarios with hand-derived constants,
// then randomized strobes checked against a behavioural model of the
// register stage and an arithmetic immediate decoder.
module tb_pc_ir_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite, PCWriteCond, PCSource, IorD, IRWrite, MemRead;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr, pc, aluout, mdr, imm;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        misalign_err;

  int checks   = 0;
  int failures = 0;

  // Reference state
  logic [31:0] mPc, mIr, mMdr, mAluout;
  logic        mErr;

  pc_ir_unit dut (
    .clk(clk), .reset(reset),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .IorD(IorD), .IRWrite(IRWrite), .MemRead(MemRead),
    .alu_result(alu_result), .alu_zero(alu_zero), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .pc(pc), .aluout(aluout), .mdr(mdr),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .misalign_err(misalign_err)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Immediate value computed numerically from the field definitions
  function automatic logic [31:0] expImm(input logic [31:0] w);
    int v;
    logic [6:0] op;
    op = w[6:0];
    v  = 0;
    case (op)
      7'h13, 7'h03, 7'h67: begin
        v = int'(w >> 20);
        if (v >= 2048) v = v - 4096;
      end
      7'h23: begin
        v = int'(w[31:25]) * 32 + int'(w[11:7]);
        if (v >= 2048) v = v - 4096;
      end
      7'h63: begin
        v = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        if (v >= 4096) v = v - 8192;
      end
      7'h37, 7'h17:
        return w & 32'hFFFF_F000;
      7'h6F: begin
        v = int'(w[31]) * (1 << 20) + int'(w[19:12]) * (1 << 12) + int'(w[20]) * (1 << 11) + int'(w[30:21]) * 2;
        if (v >= (1 << 20)) v = v - (1 << 21);
      end
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  // Advance the reference by one clock using the inputs currently driven
  task automatic modelEdge();
    logic [31:0] target;
    if (reset) begin
      mPc = 32'h0; mIr = 32'h13; mMdr = 32'h0; mAluout = 32'h0; mErr = 1'b0;
    end else begin
      target = PCSource ? mAluout : alu_result;
      if (PCWrite || (PCWriteCond && alu_zero)) begin
        mPc = (target / 4) * 4;
        if (target % 4 != 0) mErr = 1'b1;
      end
      if (IRWrite) mIr = mem_rdata;
      if (MemRead && IorD) mMdr = mem_rdata;
      mAluout = alu_result;
    end
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    PCWrite = 0; PCWriteCond = 0; PCSource = 0; IorD = 0;
    IRWrite = 0; MemRead = 0; alu_zero = 0;
  endtask

  task automatic test_reset();
    reset = 1; idleInputs(); alu_result = 32'h1234_5678; mem_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    reset = 0; alu_result = 32'h0;
    #1;
    checks++; if (pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc got %h want %h", pc, 32'h0); end
    checks++; if (opcode !== 7'b0010011) begin failures++; $display("[TB] FAIL reset_opcode got %b want %b", opcode, 7'b0010011); end
    checks++; if (imm !== 32'h0) begin failures++; $display("[TB] FAIL reset_imm got %h want %h", imm, 32'h0); end
    checks++; if (mdr !== 32'h0) begin failures++; $display("[TB] FAIL reset_mdr got %h want %h", mdr, 32'h0); end
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got %b want 0", misalign_err); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_addr got %h want %h", mem_addr, 32'h0); end
    checks++; if (aluout !== 32'h0) begin failures++; $display("[TB] FAIL reset_aluout got %h want %h", aluout, 32'h0); end
  endtask

  task automatic test_fetch();
    idleInputs();
    IRWrite = 1; PCWrite = 1; PCSource = 0; alu_result = 32'h4; mem_rdata = 32'h0040_A103;
    #1;
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("[TB] FAIL fetch_addr got %h want %h", mem_addr, 32'h0); end
    tick();
    idleInputs();
    checks++; if (opcode !== 7'b0000011) begin failures++; $display("[TB] FAIL fetch_opcode got %b want %b", opcode, 7'b0000011); end
    checks++; if (rd !== 5'd2) begin failures++; $display("[TB] FAIL fetch_rd got %0d want 2", rd); end
    checks++; if (rs1 !== 5'd1) begin failures++; $display("[TB] FAIL fetch_rs1 got %0d want 1", rs1); end
    checks++; if (imm !== 32'h4) begin failures++; $display("[TB] FAIL fetch_imm got %h want %h", imm, 32'h4); end
    checks++; if (pc !== 32'h4) begin failures++; $display("[TB] FAIL fetch_pc got %h want %h", pc, 32'h4); end
    checks++; if (mdr !== 32'h0) begin failures++; $display("[TB] FAIL fetch_mdr got %h want %h", mdr, 32'h0); end
  endtask

  task automatic test_load();
    idleInputs(); alu_result = 32'h100; mem_rdata = 32'h0;
    tick();
    IorD = 1; MemRead = 1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (mem_addr !== 32'h100) begin failures++; $display("[TB] FAIL load_addr got %h want %h", mem_addr, 32'h100); end
    tick();
    idleInputs();
    checks++; if (mdr !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL load_mdr got %h want %h", mdr, 32'hDEAD_BEEF); end
    checks++; if (opcode !== 7'b0000011 || rd !== 5'd2) begin failures++; $display("[TB] FAIL load_ir_hold got op %b rd %0d want op 0000011 rd 2", opcode, rd); end
  endtask

  task automatic test_store_decode();
    idleInputs(); IRWrite = 1; mem_rdata = 32'hFE20_AE23; alu_result = 32'h8;
    tick();
    idleInputs();
    checks++; if (opcode !== 7'b0100011) begin failures++; $display("[TB] FAIL store_opcode got %b want %b", opcode, 7'b0100011); end
    checks++; if (imm !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL store_imm got %h want %h", imm, 32'hFFFF_FFFC); end
  endtask

  task automatic test_branch();
    logic [31:0] pcBefore;
    idleInputs(); alu_result = 32'h40;
    tick();
    pcBefore = mPc;
    PCWriteCond = 1; PCSource = 1; alu_zero = 0;
    tick();
    checks++; if (pc !== pcBefore) begin failures++; $display("[TB] FAIL branch_not_taken got %h want %h", pc, pcBefore); end
    alu_zero = 1;
    tick();
    idleInputs();
    checks++; if (pc !== 32'h40) begin failures++; $display("[TB] FAIL branch_taken got %h want %h", pc, 32'h40); end
  endtask

  task automatic test_misalign_reset();
    idleInputs(); PCWrite = 1; alu_result = 32'h22;
    tick();
    idleInputs(); alu_result = 32'h0;
    checks++; if (pc !== 32'h20) begin failures++; $display("[TB] FAIL misalign_pc got %h want %h", pc, 32'h20); end
    checks++; if (misalign_err !== 1'b1) begin failures++; $display("[TB] FAIL misalign_set got %b want 1", misalign_err); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (misalign_err !== 1'b1) begin failures++; $display("[TB] FAIL misalign_sticky got %b want 1", misalign_err); end
    reset = 1; PCWrite = 1; IRWrite = 1; alu_result = 32'h80; mem_rdata = 32'h0040_A103;
    tick();
    reset = 0; idleInputs();
    checks++; if (pc !== 32'h0) begin failures++; $display("[TB] FAIL rstprec_pc got %h want %h", pc, 32'h0); end
    checks++; if ({funct7, rs2, rs1, funct3, rd, opcode} !== 32'h0000_0013) begin failures++; $display("[TB] FAIL rstprec_ir got %h want %h", {funct7, rs2, rs1, funct3, rd, opcode}, 32'h13); end
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("[TB] FAIL rstprec_err got %b want 0", misalign_err); end
  endtask

  task automatic test_random();
    logic [6:0]  opList [10];
    logic [31:0] r;
    logic [31:0] expAddr;
    opList = '{7'h03, 7'h23, 7'h63, 7'h13, 7'h33, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};
    for (int n = 0; n < 400; n++) begin
      reset       = ($urandom_range(0, 49) == 0);
      PCWrite     = ($urandom_range(0, 3) == 0);
      PCWriteCond = ($urandom_range(0, 3) == 0);
      PCSource    = 1'($urandom_range(0, 1));
      IorD        = 1'($urandom_range(0, 1));
      IRWrite     = 1'($urandom_range(0, 1));
      MemRead     = 1'($urandom_range(0, 1));
      alu_zero    = 1'($urandom_range(0, 1));
      alu_result  = $urandom;
      if ($urandom_range(0, 7) != 0) alu_result[1:0] = 2'b00;
      r = $urandom;
      mem_rdata = {r[31:7], opList[$urandom_range(0, 9)]};
      #1;
      expAddr = IorD ? mAluout : mPc;
      checks++; if (mem_addr !== expAddr) begin failures++; $display("[TB] FAIL rand_addr cyc %0d got %h want %h", n, mem_addr, expAddr); end
      tick();
      checks++; if (pc !== mPc) begin failures++; $display("[TB] FAIL rand_pc cyc %0d got %h want %h", n, pc, mPc); end
      checks++; if (aluout !== mAluout) begin failures++; $display("[TB] FAIL rand_aluout cyc %0d got %h want %h", n, aluout, mAluout); end
      checks++; if (mdr !== mMdr) begin failures++; $display("[TB] FAIL rand_mdr cyc %0d got %h want %h", n, mdr, mMdr); end
      checks++; if (misalign_err !== mErr) begin failures++; $display("[TB] FAIL rand_err cyc %0d got %b want %b", n, misalign_err, mErr); end
      checks++; if (opcode !== mIr[6:0] || rd !== mIr[11:7] || funct3 !== mIr[14:12]) begin failures++; $display("[TB] FAIL rand_fieldsA cyc %0d got %b/%0d/%0d ir %h", n, opcode, rd, funct3, mIr); end
      checks++; if (rs1 !== mIr[19:15] || rs2 !== mIr[24:20] || funct7 !== mIr[31:25]) begin failures++; $display("[TB] FAIL rand_fieldsB cyc %0d got %0d/%0d/%b ir %h", n, rs1, rs2, funct7, mIr); end
      checks++; if (imm !== expImm(mIr)) begin failures++; $display("[TB] FAIL rand_imm cyc %0d got %h want %h ir %h", n, imm, expImm(mIr), mIr); end
    end
    reset = 0;
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store_decode();
    test_branch();
    test_misalign_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
